mem_pipe_model: RTL and testbench

Parametrised data-memory model that succeeds the single-cycle data memory used in processor benches. It adds configurable read latency, a valid/ready request handshake, a post-reset zero-initialisation sequence and out-of-range error reporting. It sits between the processor's load/store port and the bench, and is addressed by word index (processor byte address with the low log2(DATA_W/8) bits dropped).

---
 rtl/mem_pipe_model.sv | 137 +++++++++++++
 tb/tb_mem_pipe_model.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_pipe_model.sv
// Word-addressed data memory with byte-masked writes, a RD_LAT-deep read pipeline,
// a valid/ready request port and an optional post-reset clear sweep.
module mem_pipe_model #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 512,
  parameter int ADDR_W    = 29,
  parameter int RD_LAT    = 1,
  parameter int INIT_ZERO = 1
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] clr_idx, clr_idx_nxt;
  logic             clr_en;
  logic             ready_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc, acc_rd, acc_wr, in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;

  logic              vld_p  [RD_LAT];
  logic [DATA_W-1:0] data_p [RD_LAT];
  logic              err_p  [RD_LAT];

  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [NB-1:0]     mask);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    clr_en      = 1'b0;
    case (state)
      ST_INIT: begin
        clr_en      = 1'b1;
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr_idx == LAST_IDX) begin
          state_nxt   = ST_RUN;
          clr_idx_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  // ready is registered so it stays low for the whole reset cycle even without INIT
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state   <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      clr_idx <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
      ready_q <= (state_nxt == ST_RUN);
    end
  end

  assign req_ready = ready_q;
  assign init_done = ready_q;

  assign acc      = req_valid & ready_q & nrst;
  assign acc_rd   = acc & ~req_we;
  assign acc_wr   = acc & req_we;
  assign in_range = ({1'b0, req_addr} < DEPTH_A);
  assign idx      = req_addr[IDX_W-1:0];
  assign rd_word  = in_range ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (nrst && clr_en) begin
      mem[clr_idx] <= '0;
    end else if (acc_wr && in_range) begin
      mem[idx] <= byte_merge(mem[idx], req_wdata, req_wmask);
    end
  end

  // read pipeline stage p0 .. p(RD_LAT-1); the last stage drives the response
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int k = 0; k < RD_LAT; k++) vld_p[k] <= 1'b0;
    end else begin
      vld_p[0] <= acc_rd;
      for (int k = 1; k < RD_LAT; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  // data only moves with a valid entry, so the last stage holds between responses
  always_ff @(posedge clk) begin
    if (acc_rd) begin
      data_p[0] <= rd_word;
      err_p[0]  <= ~in_range;
    end
    for (int k = 1; k < RD_LAT; k++) begin
      if (vld_p[k-1]) begin
        data_p[k] <= data_p[k-1];
        err_p[k]  <= err_p[k-1];
      end
    end
    if (!nrst) begin
      data_p[RD_LAT-1] <= '0;
      err_p[RD_LAT-1]  <= 1'b0;
    end
  end

  assign rsp_valid = vld_p[RD_LAT-1];
  assign rsp_rdata = data_p[RD_LAT-1];
  assign rsp_err   = err_p[RD_LAT-1];

endmodule

// File: tb/tb_mem_pipe_model.sv
// Bench for mem_pipe_model: four INIT_ZERO=1 instances with RD_LAT 1..4 share one request
// stream; an INIT_ZERO=0 instance has its own request valid.
module tb_mem_pipe_model;
  localparam int DW    = 64;
  localparam int DEPTH = 512;
  localparam int AW    = 29;
  localparam int NI    = 5;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          nrst, req_valid, req_valid4, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [7:0]    req_wmask;

  logic          rdy [NI];
  logic          rv  [NI];
  logic          re  [NI];
  logic          idn [NI];
  logic [DW-1:0] rd  [NI];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_pipe_model #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(g + 1), .INIT_ZERO(1)) dut (
      .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(rdy[g]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rv[g]),
      .rsp_rdata(rd[g]), .rsp_err(re[g]), .init_done(idn[g]));
  end

  mem_pipe_model #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(2), .INIT_ZERO(0)) dut_noinit (
    .clk(clk), .nrst(nrst), .req_valid(req_valid4), .req_ready(rdy[4]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rv[4]),
    .rsp_rdata(rd[4]), .rsp_err(re[4]), .init_done(idn[4]));

  // reference model
  typedef struct {
    int          due;
    logic [63:0] data;
    logic        err;
  } rsp_t;

  int          lat [NI] = '{1, 2, 3, 4, 2};
  bit          iz  [NI] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [63:0] mm  [NI][DEPTH];
  rsp_t        q   [NI][$];
  logic [63:0] last_d [NI];
  logic        last_e [NI];
  int          run_edges = 0;
  int          edge_n = 0;
  int          total = 0;
  int          bad = 0;

  function automatic bit mready(int i);
    return iz[i] ? (run_edges >= DEPTH) : (run_edges >= 1);
  endfunction

  task automatic chk(string tag, int i, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, i, obs, exp);
    end
  endtask

  task automatic tick();
    logic v, inr;
    rsp_t r;
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      v = (i == 4) ? req_valid4 : req_valid;
      if (!nrst) begin
        q[i].delete();
        last_d[i] = '0;
        last_e[i] = 1'b0;
      end else if (v && mready(i)) begin
        inr = ({3'b0, req_addr} < 32'(DEPTH));
        if (!req_we) begin
          r.due  = edge_n + lat[i] - 1;
          r.data = inr ? mm[i][req_addr[8:0]] : 64'h0;
          r.err  = !inr;
          q[i].push_back(r);
        end else if (inr) begin
          for (int b = 0; b < 8; b++)
            if (req_wmask[b]) mm[i][req_addr[8:0]][8*b +: 8] = req_wdata[8*b +: 8];
        end
      end
    end
    if (nrst && run_edges < DEPTH) begin
      for (int i = 0; i < NI; i++) if (iz[i]) mm[i][run_edges] = '0;
    end
    run_edges = nrst ? run_edges + 1 : 0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("req_ready", i, rdy[i], mready(i));
      chk("init_done", i, idn[i], mready(i));
      if (q[i].size() > 0 && q[i][0].due == edge_n) begin
        last_d[i] = q[i][0].data;
        last_e[i] = q[i][0].err;
        void'(q[i].pop_front());
        chk("rsp_valid", i, rv[i], 1'b1);
      end else begin
        chk("rsp_valid", i, rv[i], 1'b0);
      end
      chk("rsp_rdata", i, rd[i], last_d[i]);
      chk("rsp_err", i, re[i], last_e[i]);
    end
    edge_n++;
  endtask

  task automatic idle(int n);
    req_valid  = 1'b0;
    req_valid4 = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(int addr, logic [63:0] d, logic [7:0] m);
    req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(addr); req_wdata = d; req_wmask = m;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic rdreq(int addr);
    req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(addr);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; req_valid = 1'b0; req_valid4 = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_wmask = '0;
    for (int i = 0; i < NI; i++) begin last_d[i] = '0; last_e[i] = 1'b0; end
    idle(3);

    // INIT sweep: ready must stay low for DEPTH edges, then rise
    nrst = 1'b1;
    idle(DEPTH);

    rdreq(0); rdreq(100); rdreq(511);
    idle(5);

    wr(4, 64'h1122334455667788, 8'hFF);
    wr(4, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    rdreq(4);
    idle(5);
    for (int i = 0; i < 4; i++) chk("mask_word", i, rd[i], 64'h11223344AAAAAAAA);

    wr(1, 64'h10, 8'hFF); wr(2, 64'h20, 8'hFF); wr(3, 64'h30, 8'hFF);
    rdreq(1); rdreq(2); rdreq(3);
    idle(5);
    for (int i = 0; i < 4; i++) chk("lat_last", i, rd[i], 64'h30);

    wr(512, 64'hDEAD, 8'hFF);
    rdreq(512);
    idle(5);
    for (int i = 0; i < 4; i++) begin
      chk("oor_data", i, rd[i], 64'h0);
      chk("oor_err", i, re[i], 1'b1);
    end
    rdreq(0);
    idle(5);

    rdreq(7); wr(7, 64'h5, 8'hFF); rdreq(7);
    idle(5);
    for (int i = 0; i < 4; i++) chk("wr_then_rd", i, rd[i], 64'h5);

    // instance without INIT: written word read back
    req_valid4 = 1'b1; req_we = 1'b1; req_addr = AW'(3); req_wdata = 64'hCAFE; req_wmask = 8'hFF;
    tick();
    req_we = 1'b0;
    tick();
    idle(4);
    chk("noinit_rd", 4, rd[4], 64'hCAFE);

    for (int k = 0; k < 400; k++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1) == 1;
      req_addr  = ($urandom_range(0, 15) == 0) ? AW'(512 + $urandom_range(0, 8))
                                               : AW'($urandom_range(0, DEPTH - 1));
      req_wdata = {$urandom, $urandom};
      req_wmask = 8'($urandom);
      tick();
    end
    idle(6);

    // reset one cycle after a read is accepted: deeper pipelines must drop it
    rdreq(9);
    nrst = 1'b0;
    idle(2);
    nrst = 1'b1;
    idle(DEPTH);
    for (int k = 0; k < 20; k++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'($urandom_range(0, DEPTH - 1));
      tick();
    end
    idle(6);
    for (int i = 0; i < 4; i++) chk("post_init_zero", i, rd[i], 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
